// File: rtl/mult_rr_arbiter.sv
// mult_rr_arbiter: round-robin sharing of one 2-stage multiplier among NUM_REQ requesters
module pipelined_multiplier_2stage #(
  parameter int INPUT_WIDTH = 18
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_valid,
  input  logic [INPUT_WIDTH-1:0]     i_A,
  input  logic [INPUT_WIDTH-1:0]     i_B,
  output logic [2*INPUT_WIDTH-1:0]   o_P,
  output logic                       o_valid
);
  logic [INPUT_WIDTH-1:0]   a_q, b_q;
  logic [2*INPUT_WIDTH-1:0] p_q;
  logic                     v1_q, v2_q;
  // operand register then product register; the valid bit travels alongside
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      a_q  <= '0;
      b_q  <= '0;
      p_q  <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      a_q  <= i_A;
      b_q  <= i_B;
      v1_q <= i_valid;
      p_q  <= {{INPUT_WIDTH{1'b0}}, a_q} * {{INPUT_WIDTH{1'b0}}, b_q};
      v2_q <= v1_q;
    end
  end
  assign o_P     = p_q;
  assign o_valid = v2_q;
endmodule

module mult_rr_arbiter #(
  parameter int INPUT_WIDTH = 18,
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = 2
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] i_A,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] i_B,
  output logic [NUM_REQ-1:0]             o_gnt,
  output logic [2*INPUT_WIDTH-1:0]       o_res,
  output logic [NUM_REQ-1:0]             o_res_valid,
  output logic [ID_WIDTH-1:0]            o_res_id,
  output logic                           o_busy
);
  logic [ID_WIDTH-1:0]      ptr_q, ptr_d, gid, idx;
  logic                     found, busy_d;
  logic [NUM_REQ-1:0]       gnt;
  logic [INPUT_WIDTH-1:0]   a_mux, b_mux;
  logic                     t1_v_q, t2_v_q, m_valid;
  logic [ID_WIDTH-1:0]      t1_id_q, t2_id_q, rid_q;
  logic [2*INPUT_WIDTH-1:0] m_p, res_q;
  logic [NUM_REQ-1:0]       rv_q;
  logic                     busy_q;
  // first active request at or after the pointer, wrapping; index arithmetic wraps naturally
  always_comb begin
    gnt   = '0;
    gid   = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr_q + ID_WIDTH'(i);
      if (!found && i_req[idx]) begin
        gnt[idx] = 1'b1;
        gid      = idx;
        found    = 1'b1;
      end
    end
  end
  assign ptr_d  = found ? gid + 1'b1 : ptr_q;
  assign busy_d = found | t1_v_q | t2_v_q;
  assign a_mux  = found ? i_A[int'(gid)*INPUT_WIDTH +: INPUT_WIDTH] : '0;
  assign b_mux  = found ? i_B[int'(gid)*INPUT_WIDTH +: INPUT_WIDTH] : '0;
  pipelined_multiplier_2stage #(.INPUT_WIDTH(INPUT_WIDTH)) u_mult (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (found),
    .i_A     (a_mux),
    .i_B     (b_mux),
    .o_P     (m_p),
    .o_valid (m_valid)
  );
  // pointer, tag pipe matched to multiplier latency, and result register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr_q   <= '0;
      t1_v_q  <= 1'b0;
      t1_id_q <= '0;
      t2_v_q  <= 1'b0;
      t2_id_q <= '0;
      res_q   <= '0;
      rv_q    <= '0;
      rid_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      t1_v_q  <= found;
      t1_id_q <= gid;
      t2_v_q  <= t1_v_q;
      t2_id_q <= t1_id_q;
      busy_q  <= busy_d;
      rv_q    <= '0;
      if (m_valid && t2_v_q) begin
        res_q <= m_p;
        rid_q <= t2_id_q;
        rv_q  <= NUM_REQ'(1) << t2_id_q;
      end
    end
  end
  assign o_gnt       = gnt;
  assign o_res       = res_q;
  assign o_res_valid = rv_q;
  assign o_res_id    = rid_q;
  assign o_busy      = busy_q;
endmodule

// File: tb/tb_mult_rr_arbiter.sv
// tb_mult_rr_arbiter: directed checks of arbitration order, result steering and reset behaviour
module tb_mult_rr_arbiter;
  localparam int W = 18;
  localparam int N = 4;
  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a, b;
  logic [N-1:0]   gnt, rv;
  logic [2*W-1:0] res;
  logic [1:0]     rid;
  logic           busy;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mult_rr_arbiter #(.INPUT_WIDTH(W), .NUM_REQ(N), .ID_WIDTH(2)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req       (req),
    .i_A         (a),
    .i_B         (b),
    .o_gnt       (gnt),
    .o_res       (res),
    .o_res_valid (rv),
    .o_res_id    (rid),
    .o_busy      (busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic put(input int k, input logic [W-1:0] av, input logic [W-1:0] bv);
    a[k*W +: W] = av;
    b[k*W +: W] = bv;
  endtask
  initial begin
    rst = 1'b1;
    req = '0;
    a   = '0;
    b   = '0;
    cyc;
    cyc;
    chk("rst_res", 64'(res), 0);
    chk("rst_rv", 64'(rv), 0);
    chk("rst_id", 64'(rid), 0);
    chk("rst_busy", 64'(busy), 0);
    rst = 1'b0;
    cyc;
    req = 4'b0100;
    put(2, 18'd5123, 18'd1234);
    #1 chk("single_gnt", 64'(gnt), 4'b0100);
    cyc;
    req = '0;
    chk("single_busy1", 64'(busy), 1);
    chk("single_rv1", 64'(rv), 0);
    cyc;
    chk("single_busy2", 64'(busy), 1);
    chk("single_rv2", 64'(rv), 0);
    cyc;
    chk("single_rv", 64'(rv), 4'b0100);
    chk("single_res", 64'(res), 6321782);
    chk("single_id", 64'(rid), 2);
    chk("single_busy3", 64'(busy), 1);
    cyc;
    chk("single_rv_off", 64'(rv), 0);
    chk("single_busy_off", 64'(busy), 0);
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    for (int k = 0; k < N; k++) put(k, W'(k + 2), 18'd3);
    for (int c = 0; c < 8; c++) begin
      req = (c < 5) ? 4'hF : 4'h0;
      #1 chk("all_gnt", 64'(gnt), (c < 5) ? 64'(1) << (c % 4) : 0);
      cyc;
      if (c >= 2 && c <= 6) begin
        chk("all_rv", 64'(rv), 64'(1) << ((c - 2) % 4));
        chk("all_res", 64'(res), 64'((((c - 2) % 4) + 2) * 3));
        chk("all_id", 64'(rid), 64'((c - 2) % 4));
        chk("all_busy", 64'(busy), 1);
      end else begin
        chk("all_rv_idle", 64'(rv), 0);
      end
    end
    req = 4'b1000;
    #1 chk("wrap_gnt3", 64'(gnt), 4'b1000);
    cyc;
    req = 4'b1001;
    #1 chk("wrap_gnt0", 64'(gnt), 4'b0001);
    cyc;
    #1 chk("wrap_gnt3b", 64'(gnt), 4'b1000);
    cyc;
    req = '0;
    chk("wrap_rv3", 64'(rv), 4'b1000);
    cyc;
    chk("wrap_rv0", 64'(rv), 4'b0001);
    cyc;
    chk("wrap_rv3b", 64'(rv), 4'b1000);
    cyc;
    cyc;
    chk("wrap_busy", 64'(busy), 0);
    req = 4'hF;
    #1 chk("wd_gnt0", 64'(gnt), 4'b0001);
    cyc;
    req = 4'b1101;
    #1 chk("wd_gnt2", 64'(gnt), 4'b0100);
    cyc;
    #1 chk("wd_gnt3", 64'(gnt), 4'b1000);
    cyc;
    req = '0;
    chk("wd_rv0", 64'(rv), 4'b0001);
    cyc;
    chk("wd_rv2", 64'(rv), 4'b0100);
    cyc;
    chk("wd_rv3", 64'(rv), 4'b1000);
    cyc;
    chk("wd_rv_end", 64'(rv), 0);
    chk("wd_busy", 64'(busy), 0);
    req = 4'b0001;
    put(0, 18'h3FFFF, 18'h3FFFF);
    #1 chk("max_gnt", 64'(gnt), 4'b0001);
    cyc;
    req = '0;
    cyc;
    cyc;
    chk("max_rv", 64'(rv), 4'b0001);
    chk("max_res", 64'(res), 64'h0000_000F_FFF8_0001);
    cyc;
    req = 4'b0011;
    #1 chk("mr_gnt1", 64'(gnt), 4'b0010);
    cyc;
    #1 chk("mr_gnt0", 64'(gnt), 4'b0001);
    cyc;
    req = '0;
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    chk("mr_busy", 64'(busy), 0);
    chk("mr_rv", 64'(rv), 0);
    req = 4'b0011;
    #1 chk("mr_ptr", 64'(gnt), 4'b0001);
    cyc;
    req = '0;
    chk("mr_rv_a", 64'(rv), 0);
    cyc;
    chk("mr_rv_b", 64'(rv), 0);
    cyc;
    chk("mr_rv_new", 64'(rv), 4'b0001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
